// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, timing defaults per clock rate,
// host command bytes and the host-to-device frame layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        OK,
        FAIL
    } ps2_tx_state_e;

    // 130 MHz timing: 100 us inhibit, 15 ms start timeout, 2 ms transfer timeout
    localparam int unsigned INHIBIT_CYCLES_130M = 13_000;
    localparam int unsigned START_TIMEOUT_130M  = 1_950_000;
    localparam int unsigned XFER_TIMEOUT_130M   = 260_000;

    localparam int unsigned INHIBIT_CYCLES_65M  = 6_500;
    localparam int unsigned START_TIMEOUT_65M   = 975_000;
    localparam int unsigned XFER_TIMEOUT_65M    = 130_000;

    localparam int unsigned FILTER_LEN_DEFAULT  = 8;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    // Bits after the start bit, LSB first on the wire.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    localparam int unsigned FRAME_W = $bits(ps2_frame_t);

    function automatic ps2_frame_t make_frame(input logic [7:0] data);
        ps2_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^data;
        f.data   = data;
        return f;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, run-length glitch filter,
// and a one-cycle strobe on each falling edge of the filtered level.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] run_q, run_d;
    logic             level_q, level_d;
    logic             prev_q;
    logic             fall_q;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        level_d = level_q;
        run_d   = run_q;
        if (sync_q[1] == level_q) begin
            run_d = '0;
        end else if (run_q == CNT_W'(FILTER_LEN - 1)) begin
            level_d = sync_q[1];
            run_d   = '0;
        end else begin
            run_d = run_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            run_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            run_q   <= run_d;
            level_q <= level_d;
            prev_q  <= level_q;
            fall_q  <= prev_q & ~level_q;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pins through
// active-high pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_130M,
    parameter int unsigned START_TIMEOUT  = START_TIMEOUT_130M,
    parameter int unsigned XFER_TIMEOUT   = XFER_TIMEOUT_130M,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned MAX_T_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned MAX_T   = (MAX_T_A > XFER_TIMEOUT) ? MAX_T_A : XFER_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_T);
    localparam int unsigned BIT_W   = 4;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);

    ps2_tx_state_e      state_q, state_d;
    ps2_frame_t         frame_q, frame_d;
    logic [FRAME_W-1:0] frame_bits;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall;
    logic unused_lines;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data_in),
        .level_o (data_lvl),
        .fall_o  (data_fall)
    );

    assign unused_lines = clk_lvl ^ data_fall;
    assign frame_bits   = frame_q;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        clk_oe_d  = 1'b0;
        data_oe_d = data_oe_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                if (tx_valid && ready_q) begin
                    frame_d  = make_frame(tx_data);
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    clk_oe_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes out during the last clock-low cycle.
                clk_oe_d  = 1'b1;
                data_oe_d = (32'(cnt_q) + 32'd2 >= INHIBIT_CYCLES);
                if (cnt_q == INHIBIT_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                data_oe_d = 1'b1;
                if (cnt_q == START_LAST) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = FAIL;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_bits[0];
                    bitcnt_d  = BIT_W'(1);
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Edge 10 puts out the stop bit, i.e. releases data.
                if (cnt_q == XFER_LAST) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = FAIL;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_bits[bitcnt_q];
                    bitcnt_d  = bitcnt_q + BIT_W'(1);
                    if (bitcnt_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                data_oe_d = 1'b0;
                if (cnt_q == XFER_LAST) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end else if (clk_fall) begin
                    if (!data_lvl) begin
                        done_d  = 1'b1;
                        state_d = OK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FAIL;
                    end
                end
            end
            OK, FAIL: begin
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device clocking at a
// 400-cycle period on the shared open-drain lines.
module tb_ps2_host_tx;

    localparam int unsigned INH = 100;
    localparam int unsigned STO = 2000;
    localparam int unsigned XTO = 20000;
    localparam int unsigned FL  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pin, ps2_data_pin;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   done_cnt = 0, err_cnt = 0, wide_cnt = 0, both_cnt = 0;
    int   done_cyc = 0, err_cyc = 0, oe_rise_cyc = 0;
    logic done_prev = 1'b0, err_prev = 1'b0, oe_prev = 1'b0;

    assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping sampled between clock edges.
    always @(negedge clk) begin
        if (tx_done && !done_prev) begin done_cnt++; done_cyc = cyc; end
        if (tx_done && done_prev) wide_cnt++;
        if (tx_err && !err_prev) begin err_cnt++; err_cyc = cyc; end
        if (tx_err && err_prev) wide_cnt++;
        if (tx_done && tx_err) both_cnt++;
        if (ps2_clk_oe && !oe_prev) oe_rise_cyc = cyc;
        done_prev = tx_done;
        err_prev  = tx_err;
        oe_prev   = ps2_clk_oe;
    end

    task automatic send(input logic [7:0] d, input bit hold);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Device side: measure inhibit, then clock n_edges falls, sampling data in
    // each high phase; bits[0] is the start bit, bits[10] the stop bit.
    task automatic dev_run(input bit nack, input int n_edges,
                           output logic [10:0] bits, output int low_cycles);
        int t;
        bits = '0;
        low_cycles = 0;
        t = 0;
        while (!ps2_clk_oe && t < 200) begin t++; @(negedge clk); end
        while (ps2_clk_oe && low_cycles < 1000) begin low_cycles++; @(negedge clk); end
        repeat (50) @(negedge clk);
        for (int i = 0; i < n_edges; i++) begin
            repeat (100) @(negedge clk);
            bits[i] = ps2_data_pin;
            if (i == 10) begin
                if (!nack) dev_data_low = 1'b1;
                repeat (100) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
            end else begin
                repeat (100) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (200) @(negedge clk);
                dev_clk_low = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", tx_err); end
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
        rst = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_send_f4();
        logic [10:0] bits;
        int low, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 1'b0);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL f4_ready_drop: got %b expected 0", tx_ready); end
        checks++; if (ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL f4_clk_oe_rise: got %b expected 1", ps2_clk_oe); end
        dev_run(1'b0, 11, bits, low);
        checks++; if (low != 100) begin errors++; $display("FAIL f4_inhibit_len: got %0d expected 100", low); end
        checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL f4_bits: got %b expected %b", bits, 11'b1_0_11110100_0); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL f4_done_pulses: got %0d expected 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL f4_err_pulses: got %0d expected 0", err_cnt - e0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL f4_ready_after: got %b expected 1", tx_ready); end
    endtask

    task automatic test_send_ff();
        logic [10:0] bits;
        int low, d0;
        d0 = done_cnt;
        send(8'hFF, 1'b0);
        dev_run(1'b0, 11, bits, low);
        checks++; if (bits !== 11'b1_1_11111111_0) begin errors++; $display("FAIL ff_bits: got %b expected %b", bits, 11'b1_1_11111111_0); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ff_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        int low, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00, 1'b0);
        dev_run(1'b1, 11, bits, low);
        checks++; if (bits !== 11'b1_1_00000000_0) begin errors++; $display("FAIL nack_bits: got %b expected %b", bits, 11'b1_1_00000000_0); end
        repeat (20) @(negedge clk);
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL nack_err_pulses: got %0d expected 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL nack_done_pulses: got %0d expected 0", done_cnt - d0); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL nack_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
    endtask

    task automatic test_start_timeout();
        int t, rel, e0;
        e0 = err_cnt;
        send(8'h00, 1'b0);
        t = 0;
        while (ps2_clk_oe && t < 1000) begin t++; @(negedge clk); end
        rel = cyc;
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL to_release: got %b expected 0", ps2_clk_oe); end
        t = 0;
        while (err_cnt == e0 && t < 3000) begin t++; @(negedge clk); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL to_err_pulses: got %0d expected 1", err_cnt - e0); end
        checks++; if (err_cyc - rel != 2000) begin errors++; $display("FAIL to_latency: got %0d expected 2000", err_cyc - rel); end
        repeat (3) @(negedge clk);
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL to_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        int low, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00, 1'b0);
        dev_run(1'b0, 5, bits, low);
        // Edge 5 drove d4 = 0, so data is being pulled low.
        checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_data_oe: got %b expected 1", ps2_data_oe); end
        rst = 1'b0;
        #1;
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL mid_async_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 + err_cnt - e0 != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d expected 0", done_cnt - d0 + err_cnt - e0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", tx_ready); end
        send(8'hF4, 1'b0);
        dev_run(1'b0, 11, bits, low);
        checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL mid_f4_bits: got %b expected %b", bits, 11'b1_0_11110100_0); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL mid_f4_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        int low, d0;
        d0 = done_cnt;
        send(8'hF4, 1'b1);
        tx_data = 8'h55;
        dev_run(1'b0, 11, bits, low);
        tx_valid = 1'b0;
        checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL b2b_first_bits: got %b expected %b", bits, 11'b1_0_11110100_0); end
        // Done pulse cycle, then tx_ready cycle accepts, then clk_oe rises.
        checks++; if (oe_rise_cyc - done_cyc != 2) begin errors++; $display("FAIL b2b_restart: got %0d expected 2", oe_rise_cyc - done_cyc); end
        dev_run(1'b0, 11, bits, low);
        checks++; if (bits !== 11'b1_1_01010101_0) begin errors++; $display("FAIL b2b_second_bits: got %b expected %b", bits, 11'b1_1_01010101_0); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt - d0); end
    endtask

    task automatic test_pulse_shape();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
        checks++; if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d expected 0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_send_f4();
        test_send_ff();
        test_nack();
        test_start_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_pulse_shape();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
